progmem_rww_sequencer: RTL and testbench

//  Sequences page erase/program operations on the program-memory array and arbitrates the array

---
 rtl/progmem_rww_sequencer.sv | 166 ++++++++++++++++
 tb/tb_progmem_rww_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/progmem_rww_sequencer.sv
// Page erase/program sequencer and read-while-write arbiter for the
// program-memory array. The array is split into an RWW section and an NRWW
// (boot) section by the top three address bits. A page operation on one
// section still lets CPU fetches into the other section through in the
// same cycle.
module progmem_rww_sequencer #(
  parameter int              ADR_W     = 14,
  parameter int              TMR_W     = 16,
  parameter logic [TMR_W-1:0] ERASE_CYC = 16'd64,
  parameter logic [TMR_W-1:0] PROG_CYC  = 16'd64,
  parameter logic [2:0]      NRWW_TAG  = 3'b111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_req,
  input  logic [ADR_W-1:0] fetch_adr,
  output logic             fetch_gnt,
  output logic             fetch_stall,
  input  logic             pg_req,
  input  logic [1:0]       pg_op,
  input  logic [ADR_W-1:0] pg_adr,
  input  logic             pg_abort,
  output logic             pg_busy,
  output logic             pg_done,
  output logic             pg_err,
  output logic             mem_rd,
  output logic [ADR_W-1:0] mem_radr,
  output logic             mem_erase,
  output logic             mem_prog,
  output logic [ADR_W-1:0] mem_wadr,
  output logic [1:0]       mem_bksel
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ERASE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_PROG  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [1:0]       op_q, op_nxt;
  logic [ADR_W-1:0] wadr_nxt;
  logic             err_nxt;
  logic             conflict;

  // An address belongs to the NRWW section when its top three bits carry the tag.
  function automatic logic is_nrww(input logic [ADR_W-1:0] a);
    return a[ADR_W-1 -: 3] == NRWW_TAG;
  endfunction

  // Next-state, timer, latched request and rejection decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_nxt = state;
    timer_nxt = timer;
    op_nxt    = op_q;
    wadr_nxt  = mem_wadr;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        // Abort is meaningless here; a simultaneous request still wins.
        if (pg_req) begin
          if (pg_op != 2'b00) begin
            op_nxt   = pg_op;
            wadr_nxt = pg_adr;
            if (pg_op[0]) begin
              state_nxt = S_ERASE;
              timer_nxt = ERASE_CYC - 1'b1;
            end else begin
              state_nxt = S_PROG;
              timer_nxt = PROG_CYC - 1'b1;
            end
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_ERASE: begin
        err_nxt = pg_req;
        if (pg_abort) begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
        end else if (timer == '0) begin
          state_nxt = (op_q == 2'b11) ? S_GAP : S_DONE;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_GAP: begin
        err_nxt = pg_req;
        if (pg_abort) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_PROG;
          timer_nxt = PROG_CYC - 1'b1;
        end
      end
      S_PROG: begin
        err_nxt = pg_req;
        if (pg_abort) begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
        end else if (timer == '0) begin
          state_nxt = S_DONE;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_DONE: begin
        err_nxt   = pg_req;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, timer and latched operation registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      op_q     <= 2'b00;
      mem_wadr <= '0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      op_q     <= op_nxt;
      mem_wadr <= wadr_nxt;
    end
  end

  // Status and array strobes are registered from the next state so they are
  // glitch-free and drop asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pg_busy   <= 1'b0;
      pg_done   <= 1'b0;
      pg_err    <= 1'b0;
      mem_erase <= 1'b0;
      mem_prog  <= 1'b0;
    end else begin
      pg_busy   <= (state_nxt == S_ERASE) || (state_nxt == S_GAP) || (state_nxt == S_PROG);
      pg_done   <= (state_nxt == S_DONE);
      pg_err    <= err_nxt;
      mem_erase <= (state_nxt == S_ERASE);
      mem_prog  <= (state_nxt == S_PROG);
    end
  end

  // Same-cycle fetch arbitration and bank select.
  always_comb begin
    conflict    = pg_busy && (is_nrww(fetch_adr) == is_nrww(mem_wadr));
    fetch_gnt   = fetch_req && !conflict;
    fetch_stall = fetch_req && !fetch_gnt;
    mem_rd      = fetch_gnt;
    mem_radr    = fetch_adr;
    if (!pg_busy)       mem_bksel = 2'b00;
    else if (fetch_gnt) mem_bksel = is_nrww(mem_wadr) ? 2'b01 : 2'b10;
    else                mem_bksel = 2'b11;
  end

endmodule

// File: tb/tb_progmem_rww_sequencer.sv
// Self-checking bench for progmem_rww_sequencer. The reference model keeps a
// queue of per-cycle expected strobes {busy, erase, prog, done} that is filled
// with the whole operation timeline when a request is accepted.
module tb_progmem_rww_sequencer;

  localparam int ADR_W = 14;
  localparam int E_CYC = 4;
  localparam int P_CYC = 3;

  logic             clk = 1'b1;
  logic             rst;
  logic             fetch_req;
  logic [ADR_W-1:0] fetch_adr;
  logic             fetch_gnt, fetch_stall;
  logic             pg_req;
  logic [1:0]       pg_op;
  logic [ADR_W-1:0] pg_adr;
  logic             pg_abort;
  logic             pg_busy, pg_done, pg_err;
  logic             mem_rd, mem_erase, mem_prog;
  logic [ADR_W-1:0] mem_radr, mem_wadr;
  logic [1:0]       mem_bksel;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [3:0]       sched[$];
  logic [ADR_W-1:0] exp_wadr = '0;
  logic             err_now  = 1'b0;

  progmem_rww_sequencer #(
    .ADR_W(ADR_W), .TMR_W(16), .ERASE_CYC(16'd4), .PROG_CYC(16'd3), .NRWW_TAG(3'b111)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_adr(fetch_adr), .fetch_gnt(fetch_gnt), .fetch_stall(fetch_stall),
    .pg_req(pg_req), .pg_op(pg_op), .pg_adr(pg_adr), .pg_abort(pg_abort),
    .pg_busy(pg_busy), .pg_done(pg_done), .pg_err(pg_err),
    .mem_rd(mem_rd), .mem_radr(mem_radr), .mem_erase(mem_erase), .mem_prog(mem_prog),
    .mem_wadr(mem_wadr), .mem_bksel(mem_bksel)
  );

  always #5 clk = ~clk;

  function automatic logic sec(input logic [ADR_W-1:0] a);
    return a[ADR_W-1:ADR_W-3] == 3'b111;
  endfunction

  function automatic logic [3:0] cur_slot();
    return (sched.size() > 0) ? sched[0] : 4'b0000;
  endfunction

  function automatic logic exp_gnt();
    logic [3:0] c;
    c = cur_slot();
    return fetch_req && !(c[3] && (sec(fetch_adr) == sec(exp_wadr)));
  endfunction

  function automatic logic [1:0] exp_bksel();
    logic [3:0] c;
    c = cur_slot();
    if (!c[3])          return 2'b00;
    else if (exp_gnt()) return sec(exp_wadr) ? 2'b01 : 2'b10;
    else                return 2'b11;
  endfunction

  // Advance the model by one clock using the inputs currently applied, then
  // clock the DUT and return at the following falling edge.
  task automatic tick();
    logic [3:0] c;
    logic       idle, err_next;
    c        = cur_slot();
    idle     = (sched.size() == 0);
    err_next = 1'b0;
    if (!idle) void'(sched.pop_front());
    if (pg_abort && c[3]) sched.delete();
    if (pg_req) begin
      if (!idle || pg_op == 2'b00) err_next = 1'b1;
      else begin
        exp_wadr = pg_adr;
        if (pg_op[0]) for (int i = 0; i < E_CYC; i++) sched.push_back(4'b1100);
        if (pg_op == 2'b11) sched.push_back(4'b1000);
        if (pg_op[1]) for (int i = 0; i < P_CYC; i++) sched.push_back(4'b1010);
        sched.push_back(4'b0001);
      end
    end
    @(posedge clk);
    err_now = err_next;
    @(negedge clk);
  endtask

  task automatic model_reset();
    sched.delete();
    exp_wadr = '0;
    err_now  = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [ADR_W-1:0] adr);
    pg_req = 1'b1; pg_op = op; pg_adr = adr;
    tick();
    pg_req = 1'b0;
    #1;
  endtask

  // Run until the DUT returns to idle; an expired budget is a failed check.
  task automatic drain();
    int i;
    for (i = 0; i < 20; i++) begin
      if (!pg_busy && !pg_done) break;
      tick(); #1;
    end
    n_checks++;
    if (i >= 20) $display("FAIL drain_timeout busy=%b done=%b", pg_busy, pg_done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_req = 1'b0; fetch_adr = '0;
    pg_req = 1'b0; pg_op = 2'b00; pg_adr = '0; pg_abort = 1'b0;
    model_reset();
    @(negedge clk); #1;
    n_checks++;
    if ({pg_busy, pg_done, pg_err, mem_erase, mem_prog} !== 5'b0)
      $display("FAIL reset_regs got=%b exp=00000", {pg_busy, pg_done, pg_err, mem_erase, mem_prog});
    else n_pass++;
    n_checks++;
    if (mem_wadr !== '0) $display("FAIL reset_wadr got=%h exp=0000", mem_wadr);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_idle_fetch();
    fetch_req = 1'b1; fetch_adr = 14'h0123;
    #1;
    n_checks++;
    if ({fetch_gnt, mem_rd, fetch_stall, mem_bksel} !== 5'b11000 || mem_radr !== 14'h0123)
      $display("FAIL idle_fetch got gnt/rd/stall/bksel=%b radr=%h exp=11000 0123",
               {fetch_gnt, mem_rd, fetch_stall, mem_bksel}, mem_radr);
    else n_pass++;
    fetch_req = 1'b0;
  endtask

  task automatic test_erase_prog_timing();
    int n_er, n_pr, n_busy, n_done, n_gap;
    n_er = 0; n_pr = 0; n_busy = 0; n_done = 0; n_gap = 0;
    start_op(2'b11, 14'h0400);
    for (int i = 0; i < 12; i++) begin
      n_er   += int'(mem_erase);
      n_pr   += int'(mem_prog);
      n_busy += int'(pg_busy);
      n_done += int'(pg_done);
      n_gap  += int'(pg_busy && !mem_erase && !mem_prog);
      tick(); #1;
    end
    n_checks++; if (n_er != E_CYC) $display("FAIL erase_len got=%0d exp=%0d", n_er, E_CYC); else n_pass++;
    n_checks++; if (n_pr != P_CYC) $display("FAIL prog_len got=%0d exp=%0d", n_pr, P_CYC); else n_pass++;
    n_checks++; if (n_gap != 1) $display("FAIL gap_len got=%0d exp=1", n_gap); else n_pass++;
    n_checks++; if (n_busy != E_CYC + 1 + P_CYC) $display("FAIL busy_len got=%0d exp=%0d", n_busy, E_CYC + 1 + P_CYC); else n_pass++;
    n_checks++; if (n_done != 1) $display("FAIL done_len got=%0d exp=1", n_done); else n_pass++;
  endtask

  task automatic test_nrww_op();
    start_op(2'b01, 14'h3800);
    fetch_req = 1'b1; fetch_adr = 14'h0040;
    #1;
    n_checks++;
    if (fetch_gnt !== 1'b1 || mem_bksel !== 2'b01)
      $display("FAIL nrww_op_rww_fetch got gnt=%b bksel=%b exp gnt=1 bksel=01", fetch_gnt, mem_bksel);
    else n_pass++;
    fetch_adr = 14'h3900;
    #1;
    n_checks++;
    if (fetch_stall !== 1'b1 || mem_rd !== 1'b0 || mem_bksel !== 2'b11)
      $display("FAIL nrww_op_conflict got stall=%b rd=%b bksel=%b exp 1 0 11", fetch_stall, mem_rd, mem_bksel);
    else n_pass++;
    fetch_req = 1'b0;
    drain();
  endtask

  task automatic test_rww_op();
    int stalled;
    stalled = 0;
    start_op(2'b10, 14'h0100);
    fetch_req = 1'b1; fetch_adr = 14'h3A00;
    #1;
    n_checks++;
    if (fetch_gnt !== 1'b1 || mem_bksel !== 2'b10)
      $display("FAIL rww_op_nrww_fetch got gnt=%b bksel=%b exp gnt=1 bksel=10", fetch_gnt, mem_bksel);
    else n_pass++;
    fetch_adr = 14'h0200;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (fetch_gnt) break;
      stalled++;
      tick(); #1;
    end
    n_checks++;
    if (stalled != P_CYC) $display("FAIL rww_stall_len got=%0d exp=%0d", stalled, P_CYC);
    else n_pass++;
    n_checks++;
    if (pg_done !== 1'b1 || mem_bksel !== 2'b00)
      $display("FAIL rww_grant_at_done got done=%b bksel=%b exp 1 00", pg_done, mem_bksel);
    else n_pass++;
    fetch_req = 1'b0;
    drain();
  endtask

  task automatic test_err();
    start_op(2'b11, 14'h0A40);
    for (int i = 0; i < 10; i++) begin
      if (mem_prog) break;
      tick(); #1;
    end
    pg_req = 1'b1; pg_op = 2'b11; pg_adr = 14'h2222;
    tick();
    pg_req = 1'b0;
    #1;
    n_checks++;
    if (pg_err !== 1'b1 || mem_wadr !== 14'h0A40 || mem_prog !== 1'b1)
      $display("FAIL busy_req_err got err=%b wadr=%h prog=%b exp 1 0a40 1", pg_err, mem_wadr, mem_prog);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if (pg_err !== 1'b0) $display("FAIL busy_req_err_pulse got=%b exp=0", pg_err);
    else n_pass++;
    drain();
    start_op(2'b00, 14'h1111);
    n_checks++;
    if (pg_err !== 1'b1 || pg_busy !== 1'b0 || mem_wadr !== 14'h0A40)
      $display("FAIL op00_err got err=%b busy=%b wadr=%h exp 1 0 0a40", pg_err, pg_busy, mem_wadr);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if ({pg_err, pg_busy} !== 2'b00) $display("FAIL op00_after got err/busy=%b exp=00", {pg_err, pg_busy});
    else n_pass++;
  endtask

  task automatic test_abort_reset();
    int dones;
    dones = 0;
    start_op(2'b11, 14'h3800);
    tick();
    pg_abort = 1'b1;
    #1;
    n_checks++;
    if (mem_erase !== 1'b1) $display("FAIL abort_not_immediate got erase=%b exp=1", mem_erase);
    else n_pass++;
    tick();
    pg_abort = 1'b0;
    #1;
    n_checks++;
    if ({pg_busy, mem_erase, mem_prog, pg_done} !== 4'b0)
      $display("FAIL abort_idle got=%b exp=0000", {pg_busy, mem_erase, mem_prog, pg_done});
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      dones += int'(pg_done);
      tick(); #1;
    end
    n_checks++;
    if (dones != 0) $display("FAIL abort_no_done got=%0d exp=0", dones);
    else n_pass++;
    start_op(2'b10, 14'h0155);
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({pg_busy, mem_prog, mem_erase} !== 3'b000 || mem_wadr !== '0)
      $display("FAIL rst_async got busy/prog/erase=%b wadr=%h exp 000 0000", {pg_busy, mem_prog, mem_erase}, mem_wadr);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      dones += int'(pg_done) + int'(pg_busy);
      tick(); #1;
    end
    n_checks++;
    if (dones != 0) $display("FAIL rst_no_done got=%0d exp=0", dones);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] c;
    for (int i = 0; i < 600; i++) begin
      fetch_req = ($urandom_range(3) != 0);
      fetch_adr = {(($urandom_range(1) != 0) ? 3'b111 : 3'($urandom_range(6))), 11'($urandom)};
      pg_req    = ($urandom_range(7) == 0);
      pg_op     = 2'($urandom_range(3));
      pg_adr    = {(($urandom_range(1) != 0) ? 3'b111 : 3'($urandom_range(6))), 11'($urandom)};
      pg_abort  = ($urandom_range(31) == 0);
      #1;
      c = cur_slot();
      n_checks++;
      if ({pg_busy, mem_erase, mem_prog, pg_done, pg_err} !== {c, err_now})
        $display("FAIL rnd_status cyc=%0d got=%b exp=%b", i, {pg_busy, mem_erase, mem_prog, pg_done, pg_err}, {c, err_now});
      else n_pass++;
      n_checks++;
      if (fetch_gnt !== exp_gnt() || mem_rd !== exp_gnt() || fetch_stall !== (fetch_req && !exp_gnt()) ||
          mem_bksel !== exp_bksel() || mem_radr !== fetch_adr || mem_wadr !== exp_wadr)
        $display("FAIL rnd_fetch cyc=%0d got gnt=%b stall=%b bksel=%b wadr=%h exp gnt=%b bksel=%b wadr=%h",
                 i, fetch_gnt, fetch_stall, mem_bksel, mem_wadr, exp_gnt(), exp_bksel(), exp_wadr);
      else n_pass++;
      tick();
    end
    pg_req = 1'b0; pg_abort = 1'b0; fetch_req = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle_fetch();
    test_erase_prog_timing();
    test_nrww_op();
    test_rww_op();
    test_err();
    test_abort_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
